dma_bus_arbiter: RTL and testbench

//   Downstream consumer of the DMA controller's bus request. Samples br, waits
//   for any in-flight CPU memory transaction to finish, then drives bg for one

---
 rtl/dma_bus_arbiter.sv | 172 +++++++++++++++++
 tb/tb_dma_bus_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dma_bus_arbiter.sv
// Bus arbiter that grants the DMA controller one burst of BURST_WORDS words at a time,
// with a GAP_CYCLES CPU window between bursts. Optional grant watchdog: ARB_TIMEOUT_EN.
module dma_bus_arbiter #(
    parameter int BURST_WORDS = 4,
    parameter int GAP_CYCLES  = 1,
    parameter int CNT_W       = 3,
    parameter int TIMEOUT     = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             br,
    input  logic             cpu_bus_busy,
    input  logic             mem_ready,
    output logic             bg,
    output logic             cpu_stall,
    output logic             burst_done,
    output logic [CNT_W-1:0] word_idx,
    output logic             arb_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_CPU = 2'd1,
        GRANT    = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BURST_WORDS - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic             bg_nxt;
    logic             cpu_stall_nxt;
    logic             burst_done_nxt;
    logic [CNT_W-1:0] word_idx_nxt;
    logic [CNT_W-1:0] gap_cnt;
    logic [CNT_W-1:0] gap_cnt_nxt;
    logic             timeout_hit;
    logic             req_ok;

`ifdef ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wdog;

    // Watchdog restarts on every accepted word and whenever we are outside GRANT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog <= '0;
        end else if (state != GRANT || mem_ready) begin
            wdog <= '0;
        end else begin
            wdog <= wdog + WD_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arb_err <= 1'b0;
        end else if (timeout_hit) begin
            arb_err <= 1'b1;
        end
    end

    assign timeout_hit = (state == GRANT) && br && !mem_ready &&
                         (wdog == WD_W'(TIMEOUT - 1));
    assign req_ok      = br && !arb_err;
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT != 0);
    assign timeout_hit    = 1'b0;
    assign req_ok         = br;
    assign arb_err        = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bg         <= 1'b0;
            cpu_stall  <= 1'b0;
            burst_done <= 1'b0;
            word_idx   <= '0;
            gap_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            bg         <= bg_nxt;
            cpu_stall  <= cpu_stall_nxt;
            burst_done <= burst_done_nxt;
            word_idx   <= word_idx_nxt;
            gap_cnt    <= gap_cnt_nxt;
        end
    end

    // Next-state and next-output logic; outputs are the registered copies of these
    always_comb begin
        state_nxt      = state;
        bg_nxt         = 1'b0;
        cpu_stall_nxt  = 1'b0;
        burst_done_nxt = 1'b0;
        word_idx_nxt   = word_idx;
        gap_cnt_nxt    = gap_cnt;

        case (state)
            IDLE: begin
                if (req_ok) begin
                    if (cpu_bus_busy) begin
                        state_nxt     = WAIT_CPU;
                        cpu_stall_nxt = 1'b1;
                    end else begin
                        state_nxt     = GRANT;
                        bg_nxt        = 1'b1;
                        cpu_stall_nxt = 1'b1;
                    end
                end
            end

            WAIT_CPU: begin
                if (!req_ok) begin
                    state_nxt = IDLE;
                end else if (!cpu_bus_busy) begin
                    state_nxt     = GRANT;
                    bg_nxt        = 1'b1;
                    cpu_stall_nxt = 1'b1;
                end else begin
                    cpu_stall_nxt = 1'b1;
                end
            end

            GRANT: begin
                if (!br || timeout_hit) begin
                    // Abort beats a simultaneous mem_ready: the partial burst is dropped
                    state_nxt    = IDLE;
                    word_idx_nxt = '0;
                end else if (mem_ready && word_idx == LAST_WORD) begin
                    state_nxt      = RELEASE;
                    burst_done_nxt = 1'b1;
                    word_idx_nxt   = '0;
                    gap_cnt_nxt    = GAP_LOAD;
                end else begin
                    bg_nxt        = 1'b1;
                    cpu_stall_nxt = 1'b1;
                    if (mem_ready) begin
                        word_idx_nxt = word_idx + CNT_W'(1);
                    end
                end
            end

            RELEASE: begin
                if (gap_cnt != '0) begin
                    gap_cnt_nxt = gap_cnt - CNT_W'(1);
                end else if (!req_ok) begin
                    state_nxt = IDLE;
                end else if (cpu_bus_busy) begin
                    state_nxt     = WAIT_CPU;
                    cpu_stall_nxt = 1'b1;
                end else begin
                    state_nxt     = GRANT;
                    bg_nxt        = 1'b1;
                    cpu_stall_nxt = 1'b1;
                end
            end

            default: begin
                state_nxt    = IDLE;
                word_idx_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Scoreboard bench for dma_bus_arbiter: the driver queues hand-computed expectations,
// the monitor pops and compares them after each clock edge (or on an async-reset probe).
module tb_dma_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       br;
    logic       cpu_bus_busy;
    logic       mem_ready;
    logic       bg;
    logic       cpu_stall;
    logic       burst_done;
    logic [2:0] word_idx;
    logic       arb_err;

    typedef struct packed {
        logic [1:0] kind;   // 0 outputs, 1 burst_done count, 2 bg-fall count, 3 clear counts
        logic [6:0] vec;
    } ent_t;

    ent_t  q[$];
    int    checks   = 0;
    int    errors   = 0;
    int    bd_cnt   = 0;
    int    fall_cnt = 0;
    logic  bg_prev  = 1'b0;
    logic  clk_wake;
    string tag = "reset";
    event  sample_ev;

    dma_bus_arbiter #(
        .BURST_WORDS(4),
        .GAP_CYCLES (1),
        .CNT_W      (3),
        .TIMEOUT    (15)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .br          (br),
        .cpu_bus_busy(cpu_bus_busy),
        .mem_ready   (mem_ready),
        .bg          (bg),
        .cpu_stall   (cpu_stall),
        .burst_done  (burst_done),
        .word_idx    (word_idx),
        .arb_err     (arb_err)
    );

    always #5 clk = ~clk;

    always begin : monitor
        ent_t e;
        @(posedge clk or sample_ev);
        clk_wake = clk;
        #1;
        if (clk_wake) begin
            if (burst_done) bd_cnt++;
            if (bg_prev && !bg) fall_cnt++;
            bg_prev = bg;
        end
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.kind)
                2'd0: begin
                    checks++;
                    if ({bg, cpu_stall, burst_done, word_idx, arb_err} !== e.vec) begin
                        errors++;
                        $display("FAIL %s: got bg=%0b stall=%0b done=%0b idx=%0d err=%0b, want bg=%0b stall=%0b done=%0b idx=%0d err=%0b",
                                 tag, bg, cpu_stall, burst_done, word_idx, arb_err,
                                 e.vec[6], e.vec[5], e.vec[4], e.vec[3:1], e.vec[0]);
                    end
                end
                2'd1: begin
                    checks++;
                    if (bd_cnt != int'(e.vec)) begin
                        errors++;
                        $display("FAIL %s burst_done count: got %0d want %0d", tag, bd_cnt, e.vec);
                    end
                end
                2'd2: begin
                    checks++;
                    if (fall_cnt != int'(e.vec)) begin
                        errors++;
                        $display("FAIL %s bg fall count: got %0d want %0d", tag, fall_cnt, e.vec);
                    end
                end
                default: begin
                    bd_cnt   = 0;
                    fall_cnt = 0;
                end
            endcase
        end
    end

    task automatic push(input logic [1:0] kind, input logic [6:0] vec);
        ent_t e;
        e.kind = kind;
        e.vec  = vec;
        q.push_back(e);
    endtask

    // Drive inputs for the next edge and queue the outputs expected right after it
    task automatic step(input logic b, input logic bz, input logic mr,
                        input logic ebg, input logic est, input logic ebd,
                        input logic [2:0] eidx, input logic eerr = 1'b0);
        @(negedge clk);
        br           = b;
        cpu_bus_busy = bz;
        mem_ready    = mr;
        push(2'd0, {ebg, est, ebd, eidx, eerr});
    endtask

    task automatic full_burst();
        for (int w = 0; w < 4; w++) begin
            if (w < 3) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'(w + 1));
            else       step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0);
        end
    endtask

    initial begin
        reset        = 1'b1;
        br           = 1'b0;
        cpu_bus_busy = 1'b0;
        mem_ready    = 1'b0;

        tag = "reset";
        step(1'b1, 1'b0, 1'b1, 0, 0, 0, 3'd0);
        step(1'b1, 1'b0, 1'b1, 0, 0, 0, 3'd0);
        step(1'b0, 1'b0, 1'b0, 0, 0, 0, 3'd0);
        reset = 1'b0;

        tag = "t1_burst";
        step(1'b1, 1'b0, 1'b0, 1, 1, 0, 3'd0);
        full_burst();
        step(1'b1, 1'b0, 1'b0, 1, 1, 0, 3'd0);
        step(1'b0, 1'b0, 1'b0, 0, 0, 0, 3'd0);

        tag = "t2_wait_cpu";
        step(1'b1, 1'b1, 1'b0, 0, 1, 0, 3'd0);
        step(1'b1, 1'b1, 1'b0, 0, 1, 0, 3'd0);
        step(1'b1, 1'b1, 1'b0, 0, 1, 0, 3'd0);
        step(1'b1, 1'b0, 1'b0, 1, 1, 0, 3'd0);
        step(1'b0, 1'b0, 1'b0, 0, 0, 0, 3'd0);
        tag = "t2_wait_br_drop";
        step(1'b1, 1'b1, 1'b0, 0, 1, 0, 3'd0);
        step(1'b0, 1'b0, 1'b0, 0, 0, 0, 3'd0);
        tag = "t2_idle_mem_ready";
        step(1'b0, 1'b0, 1'b1, 0, 0, 0, 3'd0);

        tag = "t3_dma12";
        push(2'd3, 7'd0);
        step(1'b1, 1'b0, 1'b0, 1, 1, 0, 3'd0);
        full_burst();
        step(1'b1, 1'b0, 1'b0, 1, 1, 0, 3'd0);
        full_burst();
        step(1'b1, 1'b0, 1'b0, 1, 1, 0, 3'd0);
        full_burst();
        step(1'b0, 1'b0, 1'b0, 0, 0, 0, 3'd0);
        push(2'd1, 7'd3);
        push(2'd2, 7'd3);
        step(1'b0, 1'b0, 1'b0, 0, 0, 0, 3'd0);

        tag = "t3b_gap_busy";
        step(1'b1, 1'b0, 1'b0, 1, 1, 0, 3'd0);
        full_burst();
        step(1'b1, 1'b1, 1'b0, 0, 1, 0, 3'd0);
        step(1'b1, 1'b0, 1'b0, 1, 1, 0, 3'd0);
        step(1'b0, 1'b0, 1'b0, 0, 0, 0, 3'd0);

        tag = "t4_abort";
        push(2'd3, 7'd0);
        step(1'b1, 1'b0, 1'b0, 1, 1, 0, 3'd0);
        step(1'b1, 1'b0, 1'b1, 1, 1, 0, 3'd1);
        step(1'b1, 1'b0, 1'b1, 1, 1, 0, 3'd2);
        step(1'b0, 1'b0, 1'b1, 0, 0, 0, 3'd0);
        step(1'b0, 1'b0, 1'b0, 0, 0, 0, 3'd0);
        push(2'd1, 7'd0);
        step(1'b0, 1'b0, 1'b0, 0, 0, 0, 3'd0);

        tag = "t5_async_reset";
        step(1'b1, 1'b0, 1'b0, 1, 1, 0, 3'd0);
        step(1'b1, 1'b0, 1'b1, 1, 1, 0, 3'd1);
        @(negedge clk);
        mem_ready = 1'b0;
        #2;
        reset = 1'b1;
        push(2'd0, 7'd0);
        ->sample_ev;
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0, 0, 0, 0, 3'd0);

`ifdef ARB_TIMEOUT_EN
        tag = "t6_timeout";
        step(1'b1, 1'b0, 1'b0, 1, 1, 0, 3'd0, 1'b0);
        repeat (14) step(1'b1, 1'b0, 1'b0, 1, 1, 0, 3'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 0, 0, 0, 3'd0, 1'b1);
        repeat (3) step(1'b1, 1'b0, 1'b0, 0, 0, 0, 3'd0, 1'b1);
        tag = "t6_reset_clears";
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0, 0, 0, 0, 3'd0, 1'b0);
        reset = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1, 1, 0, 3'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 0, 0, 0, 3'd0, 1'b0);
`else
        tag = "t6_no_watchdog";
        step(1'b1, 1'b0, 1'b0, 1, 1, 0, 3'd0);
        repeat (20) step(1'b1, 1'b0, 1'b0, 1, 1, 0, 3'd0);
        step(1'b1, 1'b0, 1'b1, 1, 1, 0, 3'd1);
        step(1'b0, 1'b0, 1'b0, 0, 0, 0, 3'd0);
`endif

        @(posedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
